// File: rtl/csa_tree_level_if.sv
// Bus bundle for one registered carry-save compression level.
//
// Handshake: valid-only. The master raises in_valid for every cycle the
// three terms are meaningful; the slave raises out_valid for exactly one
// cycle per accepted input, one clock later. There is no ready and no
// backpressure, so the consumer must take every out_valid pulse.
interface csa_tree_level_if #(
  parameter int BIT_LEN = 19
);
  logic               in_valid;
  logic [BIT_LEN-1:0] term0;
  logic [BIT_LEN-1:0] term1;
  logic [BIT_LEN-1:0] term2;
  logic               out_valid;
  logic [BIT_LEN-1:0] result0;
  logic [BIT_LEN-1:0] result1;
  logic [BIT_LEN-1:0] carry_raw;

  // Producer side: drives the operands, observes the results.
  modport master (
    output in_valid, term0, term1, term2,
    input  out_valid, result0, result1, carry_raw
  );

  // Compressor side: consumes the operands, drives the results.
  modport slave (
    input  in_valid, term0, term1, term2,
    output out_valid, result0, result1, carry_raw
  );
endinterface

// File: rtl/csa_tree_level_reg.sv
// One registered level of a carry-save adder tree.
// Three operands are compressed bit by bit with full-adder cells into a
// sum word and a majority (carry) word. The carry word is realigned one
// bit left (rotated or shifted, chosen at elaboration) and everything is
// registered with a single cycle of latency. No carries ripple between
// bits, so the combinational depth is one full-adder cell.
module csa_tree_level_reg #(
  parameter int BIT_LEN      = 19,
  parameter bit ROTATE_CARRY = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  csa_tree_level_if.slave        bus
);

  // Combinational compressor outputs.
  logic [BIT_LEN-1:0] sum_w;
  logic [BIT_LEN-1:0] maj_w;
  logic [BIT_LEN-1:0] realign_w;

  // Registered state, with next-state values.
  logic               out_valid_q, out_valid_d;
  logic [BIT_LEN-1:0] result0_q,   result0_d;
  logic [BIT_LEN-1:0] result1_q,   result1_d;
  logic [BIT_LEN-1:0] carry_raw_q, carry_raw_d;

  // One full-adder cell per bit position; bits are fully independent.
  for (genvar i = 0; i < BIT_LEN; i++) begin : g_fa
    logic a_b, a_c, b_c;
    assign sum_w[i] = bus.term0[i] ^ bus.term1[i] ^ bus.term2[i];
    assign a_b      = bus.term0[i] & bus.term1[i];
    assign a_c      = bus.term0[i] & bus.term2[i];
    assign b_c      = bus.term1[i] & bus.term2[i];
    assign maj_w[i] = a_b | a_c | b_c;
  end

  // Carry realignment: the carry of bit i has weight 2^(i+1). In the
  // rotating form the top carry wraps into bit 0 (modular arithmetic
  // around 2^BIT_LEN - 1); otherwise it is dropped.
  if (ROTATE_CARRY) begin : g_rot
    assign realign_w = {maj_w[BIT_LEN-2:0], maj_w[BIT_LEN-1]};
  end else begin : g_shl
    assign realign_w = {maj_w[BIT_LEN-2:0], 1'b0};
  end

  // Next-state: capture on in_valid, otherwise hold data and drop valid.
  // Reset is handled in the register block so that it overrides in_valid.
  always_comb begin
    out_valid_d = bus.in_valid;
    result0_d   = result0_q;
    result1_d   = result1_q;
    carry_raw_d = carry_raw_q;
    if (bus.in_valid) begin
      result0_d   = realign_w;
      result1_d   = sum_w;
      carry_raw_d = maj_w;
    end
  end

  // Output registers with synchronous reset taking priority over data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result0_q   <= '0;
      result1_q   <= '0;
      carry_raw_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result0_q   <= result0_d;
      result1_q   <= result1_d;
      carry_raw_q <= carry_raw_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result0   = result0_q;
  assign bus.result1   = result1_q;
  assign bus.carry_raw = carry_raw_q;

endmodule

// File: tb/tb_csa_tree_level_reg.sv
// Bench for csa_tree_level_reg. Two instances share the same stimulus:
// one rotating the carry word, one shifting it. Directed table first,
// then randomized traffic against an arithmetic reference model.
module tb_csa_tree_level_reg;

  localparam int N = 19;
  localparam longint MOD = longint'(1) << N;

  typedef logic [4*N:0] exp_t; // {ov, r0_rot, r0_shl, r1, craw}

  typedef struct {
    logic         rst;
    logic         v;
    logic [N-1:0] t0, t1, t2;
    logic         e_ov;
    logic [N-1:0] e_r0_rot, e_r0_shl, e_r1, e_c;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csa_tree_level_if #(.BIT_LEN(N)) bus_rot ();
  csa_tree_level_if #(.BIT_LEN(N)) bus_shl ();

  csa_tree_level_reg #(.BIT_LEN(N), .ROTATE_CARRY(1'b1)) dut_rot (
    .clk (clk),
    .rst (rst),
    .bus (bus_rot)
  );

  csa_tree_level_reg #(.BIT_LEN(N), .ROTATE_CARRY(1'b0)) dut_shl (
    .clk (clk),
    .rst (rst),
    .bus (bus_shl)
  );

  // ---------------- scoreboard state ----------------
  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  // Reference model state (what the outputs should be after each edge).
  logic         m_ov  = 1'b0;
  logic [N-1:0] m_r0a = '0;
  logic [N-1:0] m_r0b = '0;
  logic [N-1:0] m_r1  = '0;
  logic [N-1:0] m_c   = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Column-wise counting: each column holds 0..3 ones; the low bit of the
  // count stays in place, the high bit is worth one column more.
  task automatic model_compress(input logic [N-1:0] a, b, c,
                                output logic [N-1:0] s, cy);
    s  = '0;
    cy = '0;
    for (int i = 0; i < N; i++) begin
      int cnt;
      cnt   = int'(a[i]) + int'(b[i]) + int'(c[i]);
      s[i]  = (cnt % 2) == 1;
      cy[i] = (cnt / 2) == 1;
    end
  endtask

  task automatic model_edge(input logic r, v, input logic [N-1:0] a, b, c);
    logic [N-1:0] s, cy;
    longint       cl;
    if (r) begin
      m_ov = 1'b0; m_r0a = '0; m_r0b = '0; m_r1 = '0; m_c = '0;
    end else if (v) begin
      model_compress(a, b, c, s, cy);
      cl    = longint'(cy);
      m_r0a = N'((cl * 2) % MOD + cl / (MOD / 2));
      m_r0b = N'((cl * 2) % MOD);
      m_r1  = s;
      m_c   = cy;
      m_ov  = 1'b1;
    end else begin
      m_ov = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, let the rising edge capture, then compare
  // 1 time unit later against the model's expectation for that edge.
  task automatic step(input logic r, v, input logic [N-1:0] a, b, c,
                      input string tag);
    exp_t   e;
    longint lhs, rhs;
    @(negedge clk);
    rst = r;
    bus_rot.in_valid = v; bus_rot.term0 = a; bus_rot.term1 = b; bus_rot.term2 = c;
    bus_shl.in_valid = v; bus_shl.term0 = a; bus_shl.term1 = b; bus_shl.term2 = c;
    @(posedge clk);
    model_edge(r, v, a, b, c);
    exp_q.push_back({m_ov, m_r0a, m_r0b, m_r1, m_c});
    #1;
    e = exp_q.pop_front();
    chk({tag, " rot out_valid"}, longint'(bus_rot.out_valid), longint'(e[4*N]));
    chk({tag, " rot result0"},   longint'(bus_rot.result0),   longint'(e[4*N-1:3*N]));
    chk({tag, " rot result1"},   longint'(bus_rot.result1),   longint'(e[2*N-1:N]));
    chk({tag, " rot carry_raw"}, longint'(bus_rot.carry_raw), longint'(e[N-1:0]));
    chk({tag, " shl out_valid"}, longint'(bus_shl.out_valid), longint'(e[4*N]));
    chk({tag, " shl result0"},   longint'(bus_shl.result0),   longint'(e[3*N-1:2*N]));
    chk({tag, " shl result1"},   longint'(bus_shl.result1),   longint'(e[2*N-1:N]));
    chk({tag, " shl carry_raw"}, longint'(bus_shl.carry_raw), longint'(e[N-1:0]));
    // Value identity on freshly captured data: a+b+c == sum + 2*carry.
    if (!r && v) begin
      lhs = longint'(a) + longint'(b) + longint'(c);
      rhs = longint'(bus_rot.result1) + 2 * longint'(bus_rot.carry_raw);
      chk({tag, " identity"}, rhs, lhs);
    end
  endtask

  // ---------------- test ----------------
  vec_t tbl[9];

  initial begin
    bus_rot.in_valid = 1'b0; bus_rot.term0 = '0; bus_rot.term1 = '0; bus_rot.term2 = '0;
    bus_shl.in_valid = 1'b0; bus_shl.term0 = '0; bus_shl.term1 = '0; bus_shl.term2 = '0;

    //          rst   v     t0        t1        t2        ov    r0_rot    r0_shl    r1        craw
    tbl[0] = '{1'b1, 1'b1, 19'h457ED, 19'h5F78C, 19'h5E9F9, 1'b0, 19'h00000, 19'h00000, 19'h00000, 19'h00000};
    tbl[1] = '{1'b0, 1'b1, 19'h457ED, 19'h5F78C, 19'h5E9F9, 1'b1, 19'h3EFDB, 19'h3EFDA, 19'h44998, 19'h5F7ED};
    tbl[2] = '{1'b0, 1'b0, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 1'b0, 19'h3EFDB, 19'h3EFDA, 19'h44998, 19'h5F7ED};
    tbl[3] = '{1'b0, 1'b1, 19'h40000, 19'h40000, 19'h00000, 1'b1, 19'h00001, 19'h00000, 19'h00000, 19'h40000};
    tbl[4] = '{1'b0, 1'b1, 19'h7FFFF, 19'h7FFFF, 19'h7FFFF, 1'b1, 19'h7FFFF, 19'h7FFFE, 19'h7FFFF, 19'h7FFFF};
    tbl[5] = '{1'b0, 1'b1, 19'h00000, 19'h00000, 19'h00000, 1'b1, 19'h00000, 19'h00000, 19'h00000, 19'h00000};
    tbl[6] = '{1'b0, 1'b1, 19'h00001, 19'h00001, 19'h00000, 1'b1, 19'h00002, 19'h00002, 19'h00000, 19'h00001};
    tbl[7] = '{1'b1, 1'b1, 19'h457ED, 19'h5F78C, 19'h5E9F9, 1'b0, 19'h00000, 19'h00000, 19'h00000, 19'h00000};
    tbl[8] = '{1'b0, 1'b1, 19'h457ED, 19'h5F78C, 19'h5E9F9, 1'b1, 19'h3EFDB, 19'h3EFDA, 19'h44998, 19'h5F7ED};

    // Directed table: model comparison plus the hand-computed constants.
    for (int k = 0; k < 9; k++) begin
      string tag;
      tag = $sformatf("tbl%0d", k);
      step(tbl[k].rst, tbl[k].v, tbl[k].t0, tbl[k].t1, tbl[k].t2, tag);
      chk({tag, " const out_valid"}, longint'(bus_rot.out_valid), longint'(tbl[k].e_ov));
      chk({tag, " const rot r0"},    longint'(bus_rot.result0),   longint'(tbl[k].e_r0_rot));
      chk({tag, " const shl r0"},    longint'(bus_shl.result0),   longint'(tbl[k].e_r0_shl));
      chk({tag, " const r1"},        longint'(bus_rot.result1),   longint'(tbl[k].e_r1));
      chk({tag, " const carry"},     longint'(bus_rot.carry_raw), longint'(tbl[k].e_c));
    end

    // Hold after a streamed burst: idle cycles must keep the last data.
    step(1'b0, 1'b1, 19'h12345, 19'h0ABCD, 19'h7000F, "burst0");
    step(1'b0, 1'b1, 19'h55555, 19'h2AAAA, 19'h7FFFF, "burst1");
    step(1'b0, 1'b0, 19'h00000, 19'h7FFFF, 19'h00000, "idle0");
    step(1'b0, 1'b0, 19'h11111, 19'h22222, 19'h33333, "idle1");

    // Randomized traffic: mostly valid, occasional idle and reset.
    for (int k = 0; k < 400; k++) begin
      logic         r, v;
      logic [N-1:0] a, b, c;
      r = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 75);
      a = N'($urandom);
      b = N'($urandom);
      c = N'($urandom);
      if ($urandom_range(0, 15) == 0) begin a = '1; b = '1; end
      step(r, v, a, b, c, $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_tree_level_reg.md
Name: csa_tree_level_reg

Overview:
- Registered single level of a carry-save adder tree for the BLS12_381 datapath.
- Compresses three BIT_LEN-bit operands into a two-word redundant pair: a bitwise full-adder sum word and a carry word realigned by one bit.
- The carry path is built from a per-bit full-adder array (3:2 compressor). The block feeds the next tree level or the final carry-propagate adder.

Parameters:
- BIT_LEN, 19, width of every operand and result word.
- ROTATE_CARRY, 1:
  - 1 = the carry word is rotated left by one; its MSB wraps into bit 0.
  - 0 = the carry word is shifted left by one; its MSB is dropped and bit 0 is 0.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  terms qualify this cycle.
- term0  input  BIT_LEN  operand A.
- term1  input  BIT_LEN  operand B.
- term2  input  BIT_LEN  operand Cin.
- out_valid  output  1  results valid.
- result0  output  BIT_LEN  realigned carry word.
- result1  output  BIT_LEN  sum word.
- carry_raw  output  BIT_LEN  unshifted carry word (majority), registered alongside the results.

Behaviour:
- Per bit i, combinational:
  - s[i] = term0[i] ^ term1[i] ^ term2[i].
  - c[i] = majority(term0[i], term1[i], term2[i]) = (a&b)|(a&cin)|(b&cin).
  - Implemented as BIT_LEN full-adder cells.
- Carry realignment:
  - ROTATE_CARRY=1: r0 = {c[BIT_LEN-2:0], c[BIT_LEN-1]}.
  - ROTATE_CARRY=0: r0 = {c[BIT_LEN-2:0], 1'b0}.
- No carry propagation between bits. No overflow or saturation. All words are exactly BIT_LEN bits.
- Latency is exactly 1 clock. On a rising edge with in_valid=1 and rst=0:
  - result0 <= r0, result1 <= s, carry_raw <= c.
  - out_valid <= 1.
- Rising edge with in_valid=0 and rst=0:
  - out_valid <= 0.
  - result0, result1 and carry_raw hold their previous values (no update).
- Reset: on a rising edge with rst=1, result0, result1, carry_raw and out_valid all go to 0.
  - Reset wins over a simultaneous in_valid=1; that input is discarded.
  - Reset asserted mid-stream clears any pending output the same edge.
  - The first valid input after rst deasserts produces out_valid one cycle later.
- Back-to-back in_valid=1 every cycle is fully supported: one result per clock, no bubbles.
- There is no backpressure; downstream must accept every out_valid pulse.
- Before the first clock edge, outputs are undefined until reset is applied.
- Identities the verification engineer checks every valid cycle, with carry = carry_raw:
  - term0 + term1 + term2 = result1 + 2*carry, exact and unbounded.
  - With ROTATE_CARRY=1, result0 = rotl(carry_raw, 1).

Test Plan:
- Reference vector, ROTATE_CARRY=1, BIT_LEN=19: term0=0x457ED, term1=0x5F78C, term2=0x5E9F9, in_valid=1 -> next cycle out_valid=1, carry_raw=0x5F7ED, result0=0x3EFDB, result1=0x44998.
- Same vector with ROTATE_CARRY=0 -> result0=0x3EFDA, result1=0x44998.
- MSB wrap: term0=0x40000, term1=0x40000, term2=0 -> result1=0, carry_raw=0x40000.
  - ROTATE_CARRY=1 gives result0=0x00001; ROTATE_CARRY=0 gives result0=0.
- Extremes:
  - All terms 0x7FFFF -> result1=0x7FFFF, result0=0x7FFFF.
  - All terms 0 -> both results 0.
  - term0=1, term1=1, term2=0 -> result1=0, result0=0x2.
- Handshake/hold: apply the reference vector, then in_valid=0 with terms changed to 0x7FFFF -> out_valid falls to 0 and results stay 0x3EFDB/0x44998.
  - Stream 3 consecutive distinct vectors -> 3 consecutive out_valid cycles with matching results.
- Reset: rst=1 concurrent with in_valid=1 and the reference vector -> next cycle all outputs 0 and out_valid=0.
  - Drop rst and re-apply the vector -> the correct results appear after exactly 1 cycle.
